// File: rtl/param_bankmachine.sv
// param_bankmachine: single-bank DRAM command sequencer with lookahead FIFO, timing guards and optional TMR voting.
module param_bankmachine #(
  parameter int ROW_BITS   = 14,
  parameter int COL_BITS   = 7,
  parameter int ABITS      = 14,
  parameter int COLA_SHIFT = 3,
  parameter int BA_BITS    = 3,
  parameter int BANK       = 0,
  parameter int DEPTH      = 8,
  parameter int TWTP       = 5,
  parameter int TRC        = 6,
  parameter int TRAS       = 5,
  parameter int TRP        = 2,
  parameter int TRCD       = 2,
  parameter int R          = 3,
  parameter int CLOSE_PAGE = 0
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst,
  input  logic [R-1:0]                        req_valid,
  input  logic [R-1:0]                        req_we,
  input  logic [R*(ROW_BITS+COL_BITS)-1:0]    req_addr,
  output logic [R-1:0]                        req_ready,
  output logic [R-1:0]                        req_lock,
  output logic [R-1:0]                        req_wdata_ready,
  output logic [R-1:0]                        req_rdata_valid,
  input  logic [R-1:0]                        refresh_req,
  output logic [R-1:0]                        refresh_gnt,
  output logic [R-1:0]                        cmd_valid,
  output logic [R-1:0]                        cmd_first,
  output logic [R-1:0]                        cmd_last,
  input  logic [R-1:0]                        cmd_ready,
  output logic [R*ABITS-1:0]                  cmd_a,
  output logic [R*BA_BITS-1:0]                cmd_ba,
  output logic [R-1:0]                        cmd_cas,
  output logic [R-1:0]                        cmd_ras,
  output logic [R-1:0]                        cmd_we,
  output logic [R-1:0]                        cmd_is_cmd,
  output logic [R-1:0]                        cmd_is_read,
  output logic [R-1:0]                        cmd_is_write,
  output logic                                vote_err
);
  localparam int AW = ROW_BITS + COL_BITS;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TWTP + TRC + TRAS + 2);
  localparam int WW = $clog2(TRP + TRCD + 2);
  localparam int CW = ABITS + ROW_BITS + COL_BITS + COLA_SHIFT + 11;
  localparam logic [TW-1:0] TN [3] = '{TW'(TWTP), TW'(TRC), TW'(TRAS)};
  localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_AUTOPRE = 3'd2, S_TRP = 3'd3,
                         S_ACT = 3'd4, S_TRCD = 3'd5, S_REF = 3'd6;
  function automatic logic maj(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
  function automatic logic dis(input logic [2:0] v);
    return (|v) & ~(&v);
  endfunction
  logic w_valid, w_we, w_ref, w_rdy, w_dis;
  logic [AW-1:0] w_addr;
  if (R == 3) begin : g_tmr
    logic [AW-1:0] w_a0, w_a1, w_a2;
    assign w_a0 = req_addr[0 +: AW];
    assign w_a1 = req_addr[AW +: AW];
    assign w_a2 = req_addr[2*AW +: AW];
    assign w_addr = (w_a0 & w_a1) | (w_a0 & w_a2) | (w_a1 & w_a2);
    assign w_valid = maj(req_valid);
    assign w_we = maj(req_we);
    assign w_ref = maj(refresh_req);
    assign w_rdy = maj(cmd_ready);
    assign w_dis = dis(req_valid) | dis(req_we) | dis(refresh_req) | dis(cmd_ready) |
                   (w_a0 != w_a1) | (w_a0 != w_a2);
  end else begin : g_plain
    assign w_addr = req_addr[AW-1:0];
    assign w_valid = req_valid[0];
    assign w_we = req_we[0];
    assign w_ref = refresh_req[0];
    assign w_rdy = cmd_ready[0];
    assign w_dis = 1'b0;
  end
  logic r_vote_err;
  always_ff @(posedge sys_clk) r_vote_err <= sys_rst ? 1'b0 : w_dis;
  assign vote_err = r_vote_err;
  // Lookahead FIFO: entries are {we, row, col}, head read combinationally
  logic [AW:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic [AW:0] w_head;
  logic w_fifo_rdy, w_fifo_val, w_push, w_pop, w_consumed;
  logic r_os_valid, r_os_we;
  logic [AW-1:0] r_os_addr;
  assign w_fifo_rdy = r_level != LW'(DEPTH);
  assign w_fifo_val = r_level != '0;
  assign w_push = w_valid & w_fifo_rdy;
  assign w_pop = w_fifo_val & (~r_os_valid | w_consumed);
  assign w_head = r_mem[r_rptr];
  always_ff @(posedge sys_clk) if (w_push) r_mem[r_wptr] <= {w_we, w_addr};
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_os_valid <= 1'b0;
      r_os_we <= 1'b0;
      r_os_addr <= '0;
    end else if (~r_os_valid | w_consumed) begin
      r_os_valid <= w_fifo_val;
      r_os_we <= w_head[AW];
      r_os_addr <= w_head[AW-1:0];
    end
  end
  logic [ROW_BITS-1:0] r_row, w_os_row, w_head_row;
  logic [COL_BITS-1:0] w_os_col;
  logic r_row_opened, w_row_open, w_row_close, w_hit, w_autopre, w_sel_row;
  assign w_os_row = r_os_addr[AW-1:COL_BITS];
  assign w_os_col = r_os_addr[COL_BITS-1:0];
  assign w_head_row = w_head[AW-1:COL_BITS];
  assign w_hit = r_row == w_os_row;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_row <= '0;
      r_row_opened <= 1'b0;
    end else if (w_row_close) r_row_opened <= 1'b0;
    else if (w_row_open) begin
      r_row_opened <= 1'b1;
      r_row <= w_os_row;
    end
  end
  logic [2:0] r_state, w_next;
  assign w_row_close = (r_state == S_PRE) | (r_state == S_AUTOPRE) | (r_state == S_REF);
  // Close the page early only when the next queued request would miss anyway
  assign w_autopre = (CLOSE_PAGE != 0) |
                     (w_fifo_val & r_os_valid & (w_head_row != w_os_row) & ~w_row_close);
  // Guard timers: index 0 tWTP, 1 tRC, 2 tRAS
  logic [TW-1:0] r_tcnt [3];
  logic [2:0] r_tready, w_trig;
  logic w_cv, w_cas, w_ras, w_cwe, w_is_cmd, w_is_rd, w_is_wr, w_wdr, w_rdv, w_gnt;
  assign w_trig = {w_row_open, w_row_open, w_cv & w_rdy & w_is_wr};
  always_ff @(posedge sys_clk)
    for (int t = 0; t < 3; t++)
      if (sys_rst) begin
        r_tcnt[t] <= '0;
        r_tready[t] <= 1'b1;
      end else if (w_trig[t]) begin
        r_tcnt[t] <= TN[t];
        r_tready[t] <= TN[t] == '0;
      end else if (~r_tready[t]) begin
        r_tcnt[t] <= r_tcnt[t] - TW'(1);
        r_tready[t] <= r_tcnt[t] == TW'(1);
      end
  logic [WW-1:0] r_wcnt, w_wcnt;
  always_comb begin
    w_next = r_state;
    w_wcnt = r_wcnt;
    w_cv = 1'b0;
    w_cas = 1'b0;
    w_ras = 1'b0;
    w_cwe = 1'b0;
    w_is_cmd = 1'b0;
    w_is_rd = 1'b0;
    w_is_wr = 1'b0;
    w_sel_row = 1'b0;
    w_row_open = 1'b0;
    w_wdr = 1'b0;
    w_rdv = 1'b0;
    w_gnt = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_ref) w_next = S_REF;
        else if (r_os_valid && r_row_opened && w_hit) begin
          w_cv = 1'b1;
          w_cas = 1'b1;
          w_cwe = r_os_we;
          w_is_wr = r_os_we;
          w_is_rd = ~r_os_we;
          w_wdr = w_rdy & r_os_we;
          w_rdv = w_rdy & ~r_os_we;
          if (w_rdy && w_autopre) w_next = S_AUTOPRE;
        end else if (r_os_valid) w_next = r_row_opened ? S_PRE : S_ACT;
      S_PRE:
        if (r_tready[0] && r_tready[2]) begin
          w_cv = 1'b1;
          w_ras = 1'b1;
          w_cwe = 1'b1;
          w_is_cmd = 1'b1;
          if (w_rdy) begin
            w_next = (TRP == 0) ? S_ACT : S_TRP;
            w_wcnt = WW'(TRP);
          end
        end
      S_AUTOPRE:
        if (r_tready[0] && r_tready[2]) begin
          w_next = (TRP == 0) ? S_ACT : S_TRP;
          w_wcnt = WW'(TRP);
        end
      S_TRP: begin
        w_wcnt = r_wcnt - WW'(1);
        if (r_wcnt == WW'(1)) w_next = S_ACT;
      end
      S_ACT:
        if (r_tready[1]) begin
          w_cv = 1'b1;
          w_ras = 1'b1;
          w_is_cmd = 1'b1;
          w_sel_row = 1'b1;
          if (w_rdy) begin
            w_row_open = 1'b1;
            w_next = (TRCD == 0) ? S_IDLE : S_TRCD;
            w_wcnt = WW'(TRCD);
          end
        end
      S_TRCD: begin
        w_wcnt = r_wcnt - WW'(1);
        if (r_wcnt == WW'(1)) w_next = S_IDLE;
      end
      S_REF: begin
        w_is_cmd = 1'b1;
        w_gnt = r_tready[0];
        if (!w_ref) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    r_state <= sys_rst ? S_IDLE : w_next;
    r_wcnt <= sys_rst ? '0 : w_wcnt;
  end
  assign w_consumed = w_wdr | w_rdv;
  assign req_ready = {R{w_fifo_rdy}};
  assign req_lock = {R{w_fifo_val | r_os_valid}};
  assign req_wdata_ready = {R{w_wdr}};
  assign req_rdata_valid = {R{w_rdv}};
  assign refresh_gnt = {R{w_gnt}};
  assign cmd_valid = {R{w_cv}};
  assign cmd_first = '0;
  assign cmd_last = '0;
  assign cmd_a = {R{ABITS'(w_sel_row ? CW'(w_os_row) :
                   (CW'(w_autopre) << 10) | (CW'(w_os_col) << COLA_SHIFT))}};
  assign cmd_ba = {R{BA_BITS'(BANK)}};
  assign cmd_cas = {R{w_cas}};
  assign cmd_ras = {R{w_ras}};
  assign cmd_we = {R{w_cwe}};
  assign cmd_is_cmd = {R{w_is_cmd}};
  assign cmd_is_read = {R{w_is_rd}};
  assign cmd_is_write = {R{w_is_wr}};
endmodule
